fft4_sequencer: RTL and testbench

- Frame controller for a 4-point radix-2 DIT FFT/IFFT that time-shares one external combinational butterfly unit.
- Collects 4 complex samples over a valid/ready input stream and stores them in an internal 4-entry buffer.
- Sequences 4 butterfly operations (2 stages × 2) through the shared unit, then streams X0..X3 out in natural order.
- Sits between the sample source and the spectrum consumer; owns the twiddle constants.

---
 rtl/fft4_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_fft4_sequencer.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft4_sequencer.sv
// ---------------------------------------------------------------------------
// fft4_sequencer
//   Frame controller for a 4-point radix-2 DIT FFT/IFFT. Collects four complex
//   samples, runs four butterfly operations (two stages of two) through one
//   external combinational butterfly unit, then streams X0..X3 out in natural
//   order. The twiddle constants are owned here.
//
// Ports
//   clk, rst_n          clock (rising edge) / asynchronous active-low reset
//   in_valid/in_ready   input sample handshake, in_data = x0..x3 in time order
//   inv                 0 = FFT, 1 = IFFT; captured with x0, held for the frame
//   out_valid/out_ready output bin handshake, out_data = X0..X3, out_last = X3
//   bf_a, bf_b, bf_w    operands to the shared butterfly (0 when not computing)
//   bf_out0, bf_out1    butterfly results A+B*W and A-B*W
//   busy                high whenever the sequencer is not loading samples
//
// Complex words: real in [WIDTH-1:WIDTH/2], imag in [WIDTH/2-1:0], Q1.15.
// ---------------------------------------------------------------------------
module fft4_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             inv,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic [WIDTH-1:0] bf_a,
   output logic [WIDTH-1:0] bf_b,
   output logic [WIDTH-1:0] bf_w,
   input  logic [WIDTH-1:0] bf_out0,
   input  logic [WIDTH-1:0] bf_out1,
   output logic             busy
);

   localparam int HALF = WIDTH / 2;

   // Largest positive and most negative symmetric Q1.15 values (+1 and -1).
   localparam logic [HALF-1:0]  Q_ONE       = {1'b0, {(HALF-1){1'b1}}};
   localparam logic [HALF-1:0]  Q_MINUS_ONE = {1'b1, {(HALF-2){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] W0          = {Q_ONE, {HALF{1'b0}}};
   localparam logic [WIDTH-1:0] W1_FWD      = {{HALF{1'b0}}, Q_MINUS_ONE};
   localparam logic [WIDTH-1:0] W1_INV      = {{HALF{1'b0}}, Q_ONE};

   typedef enum logic [2:0] {
      ST_LOAD,
      ST_S1P0,
      ST_S1P1,
      ST_S2P0,
      ST_S2P1,
      ST_OUT
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       ld_cnt_q, ld_cnt_d;
   logic [1:0]       out_cnt_q, out_cnt_d;
   logic             inv_q, inv_d;
   logic [WIDTH-1:0] mem_q [4];
   logic [WIDTH-1:0] mem_d [4];
   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [1:0]       rd_k;
   logic [1:0]       rd_idx;

   always_comb begin
      state_d     = state_q;
      ld_cnt_d    = ld_cnt_q;
      out_cnt_d   = out_cnt_q;
      inv_d       = inv_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      for (int i = 0; i < 4; i++) begin
         mem_d[i] = mem_q[i];
      end
      in_ready = 1'b0;
      busy     = 1'b1;
      bf_a     = '0;
      bf_b     = '0;
      bf_w     = '0;

      // Bin to present next: the current one on the priming cycle, otherwise
      // the one after the bin being accepted. After the in-place DIT stages
      // bin k lives at the bit-reversed address.
      rd_k   = out_valid_q ? out_cnt_q + 2'd1 : out_cnt_q;
      rd_idx = {rd_k[0], rd_k[1]};

      case (state_q)
         ST_LOAD: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               mem_d[ld_cnt_q] = in_data;
               ld_cnt_d        = ld_cnt_q + 2'd1;
               if (ld_cnt_q == 2'd0) begin
                  inv_d = inv;
               end
               if (ld_cnt_q == 2'd3) begin
                  state_d = ST_S1P0;
               end
            end
         end
         ST_S1P0: begin
            bf_a     = mem_q[0];
            bf_b     = mem_q[2];
            bf_w     = W0;
            mem_d[0] = bf_out0;
            mem_d[2] = bf_out1;
            state_d  = ST_S1P1;
         end
         ST_S1P1: begin
            bf_a     = mem_q[1];
            bf_b     = mem_q[3];
            bf_w     = W0;
            mem_d[1] = bf_out0;
            mem_d[3] = bf_out1;
            state_d  = ST_S2P0;
         end
         ST_S2P0: begin
            bf_a     = mem_q[0];
            bf_b     = mem_q[1];
            bf_w     = W0;
            mem_d[0] = bf_out0;
            mem_d[1] = bf_out1;
            state_d  = ST_S2P1;
         end
         ST_S2P1: begin
            bf_a      = mem_q[2];
            bf_b      = mem_q[3];
            bf_w      = inv_q ? W1_INV : W1_FWD;
            mem_d[2]  = bf_out0;
            mem_d[3]  = bf_out1;
            out_cnt_d = 2'd0;
            state_d   = ST_OUT;
         end
         ST_OUT: begin
            if (!out_valid_q) begin
               // First OUT cycle loads the output register with X0.
               out_valid_d = 1'b1;
               out_data_d  = mem_q[rd_idx];
               out_last_d  = (rd_k == 2'd3);
            end else if (out_ready) begin
               if (out_cnt_q == 2'd3) begin
                  out_valid_d = 1'b0;
                  out_data_d  = '0;
                  out_last_d  = 1'b0;
                  out_cnt_d   = 2'd0;
                  ld_cnt_d    = 2'd0;
                  state_d     = ST_LOAD;
               end else begin
                  out_cnt_d  = rd_k;
                  out_data_d = mem_q[rd_idx];
                  out_last_d = (rd_k == 2'd3);
               end
            end
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_LOAD;
         ld_cnt_q    <= 2'd0;
         out_cnt_q   <= 2'd0;
         inv_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         ld_cnt_q    <= ld_cnt_d;
         out_cnt_q   <= out_cnt_d;
         inv_q       <= inv_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
      end
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_mem
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            mem_q[gi] <= '0;
         end else begin
            mem_q[gi] <= mem_d[gi];
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_fft4_sequencer.sv
`timescale 1ns/1ps
module tb_fft4_sequencer;

   localparam int WIDTH = 32;
   localparam logic [31:0] W0     = 32'h7FFF_0000;
   localparam logic [31:0] W1_FFT = 32'h0000_8001;
   localparam logic [31:0] W1_IFT = 32'h0000_7FFF;

   typedef logic [3:0][31:0] frame_t;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             inv;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_last;
   logic [WIDTH-1:0] bf_a, bf_b, bf_w;
   logic [WIDTH-1:0] bf_out0, bf_out1;
   logic             busy;

   int errors = 0;
   int checks = 0;

   fft4_sequencer #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .inv      (inv),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_last (out_last),
      .bf_a     (bf_a),
      .bf_b     (bf_b),
      .bf_w     (bf_w),
      .bf_out0  (bf_out0),
      .bf_out1  (bf_out1),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Butterfly, per component: ((A<<15) +/- B*W) >>> 15, wrapped to 16 bits.
   function automatic logic [31:0] bfly(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] w, input bit minus);
      longint ar, ai, br, bi, wr, wi, pr, pi, r, i;
      ar = longint'($signed(a[31:16]));
      ai = longint'($signed(a[15:0]));
      br = longint'($signed(b[31:16]));
      bi = longint'($signed(b[15:0]));
      wr = longint'($signed(w[31:16]));
      wi = longint'($signed(w[15:0]));
      pr = br * wr - bi * wi;
      pi = br * wi + bi * wr;
      r  = minus ? ((ar <<< 15) - pr) : ((ar <<< 15) + pr);
      i  = minus ? ((ai <<< 15) - pi) : ((ai <<< 15) + pi);
      r  = r >>> 15;
      i  = i >>> 15;
      return {r[15:0], i[15:0]};
   endfunction

   assign bf_out0 = bfly(bf_a, bf_b, bf_w, 1'b0);
   assign bf_out1 = bfly(bf_a, bf_b, bf_w, 1'b1);

   // Reference 4-point DIT: stage 1 pairs (x0,x2),(x1,x3) with W0;
   // stage 2 pairs the results with W0 and the -j/+j twiddle.
   function automatic frame_t ref_stage1(input frame_t x);
      frame_t m;
      m[0] = bfly(x[0], x[2], W0, 1'b0);
      m[2] = bfly(x[0], x[2], W0, 1'b1);
      m[1] = bfly(x[1], x[3], W0, 1'b0);
      m[3] = bfly(x[1], x[3], W0, 1'b1);
      return m;
   endfunction

   function automatic frame_t ref_fft(input frame_t x, input logic iv);
      frame_t m, y;
      logic [31:0] w1;
      m    = ref_stage1(x);
      w1   = iv ? W1_IFT : W1_FFT;
      y[0] = bfly(m[0], m[1], W0, 1'b0);
      y[2] = bfly(m[0], m[1], W0, 1'b1);
      y[1] = bfly(m[2], m[3], w1, 1'b0);
      y[3] = bfly(m[2], m[3], w1, 1'b1);
      return y;
   endfunction

   // Expected butterfly operands for the four compute cycles, as {a,b,w}.
   function automatic logic [95:0] ref_ops(input frame_t x, input logic iv, input int step);
      frame_t m;
      m = ref_stage1(x);
      case (step)
         0:       return {x[0], x[2], W0};
         1:       return {x[1], x[3], W0};
         2:       return {m[0], m[1], W0};
         default: return {m[2], m[3], iv ? W1_IFT : W1_FFT};
      endcase
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Offer one sample until it is taken; ok=0 if the bound expires.
   task automatic push(input logic [31:0] d, input logic iv, input bit hold, output bit ok);
      bit hs;
      in_valid = 1'b1;
      in_data  = d;
      inv      = iv;
      ok       = 1'b0;
      for (int n = 0; n < 100; n++) begin
         hs = in_ready;
         cyc();
         if (hs) begin
            ok = 1'b1;
            break;
         end
      end
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic push_frame(input frame_t x, input logic iv0, input logic ivr,
                             input bit hold, output bit ok);
      bit okk;
      ok = 1'b1;
      for (int k = 0; k < 4; k++) begin
         push(x[k], (k == 0) ? iv0 : ivr, hold || (k < 3), okk);
         ok = ok & okk;
      end
   endtask

   // Accept four bins; stall randomly when asked. Returns at #1 after the
   // X3 handshake edge.
   task automatic collect(input bit stall, output frame_t got, output logic [3:0] lasts,
                          output bit ok);
      int k = 0;
      bit hs;
      got   = '0;
      lasts = '0;
      for (int n = 0; n < 300 && k < 4; n++) begin
         out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         hs = out_valid && out_ready;
         if (hs) begin
            got[k]   = out_data;
            lasts[k] = out_last;
         end
         cyc();
         if (hs) k++;
      end
      out_ready = 1'b1;
      ok = (k == 4);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cyc();
      cyc();
      checks++;
      if ({in_ready, out_valid, out_last, busy} !== 4'b1000) begin
         errors++;
         $display("FAIL reset_ctrl got {rdy,ov,last,busy}=%b expected 1000",
                  {in_ready, out_valid, out_last, busy});
      end
      checks++;
      if ({out_data, bf_a, bf_b, bf_w} !== 128'd0) begin
         errors++;
         $display("FAIL reset_data got out=%h a=%h b=%h w=%h expected all 0",
                  out_data, bf_a, bf_b, bf_w);
      end
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      $display("test_reset done");
   endtask

   task automatic test_impulse();
      frame_t x, got;
      logic [3:0] lasts;
      bit ok;
      int lat;
      x = {32'h0, 32'h0, 32'h0, 32'h1000_0000};
      push_frame(x, 1'b0, 1'b0, 1'b0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL impulse_load timeout got=0 expected=1"); end
      lat = 0;
      while (!out_valid && lat < 20) begin
         if (lat < 4) begin
            checks++;
            if ({bf_a, bf_b, bf_w} !== ref_ops(x, 1'b0, lat)) begin
               errors++;
               $display("FAIL impulse_ops step%0d got %h expected %h", lat,
                        {bf_a, bf_b, bf_w}, ref_ops(x, 1'b0, lat));
            end
            checks++;
            if ({in_ready, busy} !== 2'b01) begin
               errors++;
               $display("FAIL impulse_busy step%0d got {rdy,busy}=%b expected 01", lat,
                        {in_ready, busy});
            end
         end else begin
            checks++;
            if ({bf_a, bf_b, bf_w} !== 96'd0) begin
               errors++;
               $display("FAIL impulse_ops_idle got %h expected 0", {bf_a, bf_b, bf_w});
            end
         end
         cyc();
         lat++;
      end
      checks++;
      if (lat != 5) begin errors++; $display("FAIL impulse_latency got=%0d expected=5", lat); end
      collect(1'b0, got, lasts, ok);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (got[k] !== 32'h1000_0000) begin
            errors++;
            $display("FAIL impulse_X%0d got=%h expected=10000000", k, got[k]);
         end
      end
      checks++;
      if (!ok || lasts !== 4'b1000) begin
         errors++;
         $display("FAIL impulse_last got ok=%0d lasts=%b expected 1 1000", ok, lasts);
      end
      $display("test_impulse done");
   endtask

   task automatic test_shift();
      frame_t x, got, e_fft, e_ift;
      logic [3:0] lasts;
      bit ok;
      x     = {32'h0, 32'h0, 32'h1000_0000, 32'h0};
      e_fft = {32'h0000_0FFF, 32'hF000_0000, 32'h0000_F000, 32'h0FFF_0000};
      e_ift = {32'h0000_F000, 32'hF000_0000, 32'h0000_0FFF, 32'h0FFF_0000};
      for (int pass = 0; pass < 2; pass++) begin
         // Second pass: inv=1 on x0 only, toggled back for x1..x3.
         push_frame(x, pass == 1, 1'b0, 1'b0, ok);
         collect(1'b0, got, lasts, ok);
         checks++;
         if (!ok || got !== (pass == 1 ? e_ift : e_fft)) begin
            errors++;
            $display("FAIL shift_inv%0d got ok=%0d %h expected %h", pass, ok, got,
                     (pass == 1 ? e_ift : e_fft));
         end
         $display("test_shift inv=%0d frame %h", pass, got);
      end
   endtask

   task automatic test_random();
      frame_t x, got, exp_y;
      logic [3:0] lasts;
      logic iv;
      bit ok;
      for (int f = 0; f < 6; f++) begin
         for (int k = 0; k < 4; k++) x[k] = $urandom;
         iv    = 1'($urandom_range(0, 1));
         exp_y = ref_fft(x, iv);
         push_frame(x, iv, ~iv, 1'b0, ok);
         collect(1'b1, got, lasts, ok);
         checks++;
         if (!ok || got !== exp_y || lasts !== 4'b1000) begin
            errors++;
            $display("FAIL random_f%0d got ok=%0d %h last=%b expected %h last=1000",
                     f, ok, got, lasts, exp_y);
         end
         $display("test_random frame %0d inv=%0d out %h", f, iv, got);
      end
   endtask

   task automatic test_backpressure();
      frame_t x, exp_y;
      bit ok;
      int n;
      for (int k = 0; k < 4; k++) x[k] = $urandom;
      exp_y = ref_fft(x, 1'b0);
      push_frame(x, 1'b0, 1'b0, 1'b0, ok);
      out_ready = 1'b1;
      n = 0;
      while (!out_valid && n < 20) begin cyc(); n++; end
      checks++;
      if (out_data !== exp_y[0]) begin
         errors++;
         $display("FAIL bp_X0 got=%h expected=%h", out_data, exp_y[0]);
      end
      cyc();
      out_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         checks++;
         if ({out_valid, out_data, in_ready} !== {1'b1, exp_y[1], 1'b0}) begin
            errors++;
            $display("FAIL bp_hold%0d got ov=%0d data=%h rdy=%0d expected 1 %h 0",
                     s, out_valid, out_data, in_ready, exp_y[1]);
         end
         cyc();
      end
      out_ready = 1'b1;
      for (int k = 1; k < 4; k++) begin
         checks++;
         if ({out_valid, out_data, out_last, in_ready} !== {1'b1, exp_y[k], k == 3, 1'b0}) begin
            errors++;
            $display("FAIL bp_X%0d got ov=%0d data=%h last=%0d rdy=%0d expected 1 %h %0d 0",
                     k, out_valid, out_data, out_last, in_ready, exp_y[k], k == 3);
         end
         cyc();
      end
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         errors++;
         $display("FAIL bp_done got {rdy,ov}=%b expected 10", {in_ready, out_valid});
      end
      $display("test_backpressure done");
   endtask

   task automatic test_reset_midframe();
      frame_t x, got;
      logic [3:0] lasts;
      bit ok;
      for (int k = 0; k < 4; k++) x[k] = $urandom;
      push_frame(x, 1'b1, 1'b1, 1'b0, ok);
      cyc();
      cyc();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, out_last, busy, out_data, bf_a, bf_b, bf_w} !==
          {4'b1000, 128'd0}) begin
         errors++;
         $display("FAIL midreset_outputs got rdy=%0d ov=%0d last=%0d busy=%0d out=%h a=%h b=%h w=%h expected 1 0 0 0 and zeros",
                  in_ready, out_valid, out_last, busy, out_data, bf_a, bf_b, bf_w);
      end
      cyc();
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      x = {32'h0, 32'h0, 32'h0, 32'h1000_0000};
      push_frame(x, 1'b0, 1'b0, 1'b0, ok);
      collect(1'b0, got, lasts, ok);
      checks++;
      if (!ok || got !== {4{32'h1000_0000}} || lasts !== 4'b1000) begin
         errors++;
         $display("FAIL midreset_next got ok=%0d %h last=%b expected 10000000 x4 last=1000",
                  ok, got, lasts);
      end
      $display("test_reset_midframe done");
   endtask

   task automatic test_back_to_back();
      frame_t xa, xb, ga, gb;
      logic [3:0] la, lb;
      logic ia, ib;
      bit oka, okb, okp, okk;
      time t_a3, t_b0;
      for (int k = 0; k < 4; k++) begin xa[k] = $urandom; xb[k] = $urandom; end
      ia = 1'($urandom_range(0, 1));
      ib = ~ia;
      t_a3 = 0;
      t_b0 = 0;
      fork
         begin
            push_frame(xa, ia, ia, 1'b1, okp);
            push(xb[0], ib, 1'b1, okk);
            t_b0 = $time;
            okp = okp & okk;
            for (int k = 1; k < 4; k++) begin
               push(xb[k], ib, k < 3, okk);
               okp = okp & okk;
            end
            for (int s = 0; s < 4; s++) begin
               checks++;
               if ({bf_a, bf_b, bf_w} !== ref_ops(xb, ib, s)) begin
                  errors++;
                  $display("FAIL b2b_ops step%0d got %h expected %h", s,
                           {bf_a, bf_b, bf_w}, ref_ops(xb, ib, s));
               end
               cyc();
            end
         end
         begin
            collect(1'b0, ga, la, oka);
            t_a3 = $time;
            checks++;
            if (in_ready !== 1'b1) begin
               errors++;
               $display("FAIL b2b_ready got=%0d expected=1", in_ready);
            end
            collect(1'b0, gb, lb, okb);
         end
      join
      checks++;
      if (!okp || t_b0 != t_a3 + 10) begin
         errors++;
         $display("FAIL b2b_bubble got ok=%0d x0_time=%0t expected x0 at %0t",
                  okp, t_b0, t_a3 + 10);
      end
      checks++;
      if (!oka || ga !== ref_fft(xa, ia) || la !== 4'b1000) begin
         errors++;
         $display("FAIL b2b_frameA got %h last=%b expected %h", ga, la, ref_fft(xa, ia));
      end
      checks++;
      if (!okb || gb !== ref_fft(xb, ib) || lb !== 4'b1000) begin
         errors++;
         $display("FAIL b2b_frameB got %h last=%b expected %h", gb, lb, ref_fft(xb, ib));
      end
      $display("test_back_to_back done");
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      inv       = 1'b0;
      out_ready = 1'b1;
      test_reset();
      test_impulse();
      test_shift();
      test_random();
      test_backpressure();
      test_reset_midframe();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout expected=completion");
      $fatal(1, "watchdog expired");
   end

endmodule
